// File: rtl/clock_set_sequencer.sv
// HH:MM and alarm-code entry sequencer with 1 Hz tick generation for the clock datapath.
// Every output is driven straight from a flop; the datapath sees only range-checked digits.
module clock_set_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       alarm_edit,
    input  logic [3:0] data_in,
    output logic [3:0] digit_out,
    output logic       ld_hour1,
    output logic       ld_hour2,
    output logic       ld_min1,
    output logic       ld_min2,
    output logic       ld_alarm,
    output logic       tick,
    output logic       running,
    output logic       entry_err,
    output logic [3:0] state_dbg
);

    // state | meaning
    // H1/H2/M1/M2/AL | waiting for a valid digit with go
    // xxW            | digit accepted, waiting for go release
    // RUN            | time advancing, tick generated
    typedef enum logic [3:0] {
        S_H1  = 4'd0,  S_H1W = 4'd1,
        S_H2  = 4'd2,  S_H2W = 4'd3,
        S_M1  = 4'd4,  S_M1W = 4'd5,
        S_M2  = 4'd6,  S_M2W = 4'd7,
        S_AL  = 4'd8,  S_ALW = 4'd9,
        S_RUN = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_armed;
    logic [1:0]       r_h1;
    logic [CNT_W-1:0] r_div;
    logic             w_entry;
    logic             w_valid;
    logic             w_accept;
    logic             w_reject;
    logic [3:0]       w_value;
    logic [4:0]       w_ld_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        w_valid     = 1'b0;
        w_value     = data_in;
        w_ld_sel    = 5'b00000;
        case (r_state)
            S_H1: begin
                w_entry  = 1'b1;
                w_ld_sel = 5'b00001;
                w_valid  = (data_in <= 4'd2);
            end
            S_H2: begin
                w_entry  = 1'b1;
                w_ld_sel = 5'b00010;
                w_valid  = (r_h1 == 2'd2) ? (data_in <= 4'd3) : (data_in <= 4'd9);
            end
            S_M1: begin
                w_entry  = 1'b1;
                w_ld_sel = 5'b00100;
                w_valid  = (data_in <= 4'd5);
            end
            S_M2: begin
                w_entry  = 1'b1;
                w_ld_sel = 5'b01000;
                w_valid  = (data_in <= 4'd9);
            end
            S_AL: begin
                // Out-of-range alarm codes mean "no timer" rather than an error
                w_entry  = 1'b1;
                w_ld_sel = 5'b10000;
                w_valid  = 1'b1;
                w_value  = (data_in <= 4'd3) ? data_in : 4'hF;
            end
            S_H1W:   if (!go) w_state_nxt = S_H2;
            S_H2W:   if (!go) w_state_nxt = S_M1;
            S_M1W:   if (!go) w_state_nxt = S_M2;
            S_M2W:   if (!go) w_state_nxt = S_AL;
            S_ALW:   if (!go) w_state_nxt = S_RUN;
            S_RUN:   if (alarm_edit) w_state_nxt = S_AL;
            default: w_state_nxt = S_H1;
        endcase
        w_accept = w_entry & go & r_armed & w_valid;
        w_reject = w_entry & go & r_armed & ~w_valid;
        if (w_accept) w_state_nxt = state_t'(r_state + 4'd1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_H1;
            r_armed   <= 1'b1;
            r_h1      <= 2'd0;
            r_div     <= '0;
            digit_out <= 4'd0;
            ld_hour1  <= 1'b0;
            ld_hour2  <= 1'b0;
            ld_min1   <= 1'b0;
            ld_min2   <= 1'b0;
            ld_alarm  <= 1'b0;
            tick      <= 1'b0;
            running   <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            running <= (w_state_nxt == S_RUN);
            {ld_alarm, ld_min2, ld_min1, ld_hour2, ld_hour1} <= w_ld_sel & {5{w_accept}};
            if (w_accept) begin
                digit_out <= w_value;
                entry_err <= 1'b0;
            end else if (w_reject) begin
                entry_err <= 1'b1;
            end
            // A rejected press must be released before the next evaluation
            if (w_reject)  r_armed <= 1'b0;
            else if (!go)  r_armed <= 1'b1;
            if (w_accept && r_state == S_H1) r_h1 <= data_in[1:0];
            // Divider only runs in RUN so a partial second survives alarm edits
            tick <= (r_state == S_RUN) && (r_div == DIV_LAST);
            if (r_state == S_RUN) begin
                if (r_div == DIV_LAST) r_div <= '0;
                else                   r_div <= r_div + CNT_W'(1);
            end
        end
    end

    assign state_dbg = r_state;

endmodule

// File: tb/tb_clock_set_sequencer.sv
// Directed bench for clock_set_sequencer: cycle-by-cycle check against an entry/run model
// plus hand-computed expectations for the key scenarios.
module tb_clock_set_sequencer;
    localparam int TD = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       go = 1'b0;
    logic       alarm_edit = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] digit_out, state_dbg;
    logic       ld_hour1, ld_hour2, ld_min1, ld_min2, ld_alarm;
    logic       tick, running, entry_err;

    clock_set_sequencer #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn), .go(go), .alarm_edit(alarm_edit), .data_in(data_in),
        .digit_out(digit_out), .ld_hour1(ld_hour1), .ld_hour2(ld_hour2), .ld_min1(ld_min1),
        .ld_min2(ld_min2), .ld_alarm(ld_alarm), .tick(tick), .running(running),
        .entry_err(entry_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Model: pos = digit position 0..4 (H1,H2,M1,M2,AL), 5 = running
    int         m_pos = 0;
    bit         m_wait = 0;
    bit         m_armed = 1;
    int         m_h1 = 0;
    bit         m_err = 0;
    int         m_dig = 0;
    int         m_div = 0;
    logic [4:0] m_ld = 5'd0;
    bit         m_tick = 0;

    function automatic int limit_of(input int p, input int h1);
        case (p)
            0:       return 2;
            1:       return (h1 == 2) ? 3 : 9;
            2:       return 5;
            3:       return 9;
            default: return 15;
        endcase
    endfunction

    task automatic model_reset();
        m_pos = 0; m_wait = 0; m_armed = 1; m_h1 = 0; m_err = 0;
        m_dig = 0; m_div = 0; m_ld = 5'd0; m_tick = 0;
    endtask

    task automatic model_step();
        int d;
        d = int'(data_in);
        m_ld = 5'd0;
        m_tick = 0;
        if (m_pos == 5) begin
            m_tick = (m_div == TD - 1);
            m_div = (m_div + 1) % TD;
            if (alarm_edit) begin m_pos = 4; m_wait = 0; end
        end else if (m_wait) begin
            if (!go) begin m_wait = 0; m_pos = m_pos + 1; end
        end else if (go && m_armed) begin
            if (d <= limit_of(m_pos, m_h1)) begin
                m_ld[m_pos] = 1'b1;
                m_dig = (m_pos == 4 && d > 3) ? 15 : d;
                if (m_pos == 0) m_h1 = d;
                m_err = 0;
                m_wait = 1;
            end else begin
                m_err = 1;
                m_armed = 0;
            end
        end
        if (!go) m_armed = 1;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;
    int c_ld [5] = '{0, 0, 0, 0, 0};

    always @(negedge clk) begin
        if (ld_hour1) c_ld[0] <= c_ld[0] + 1;
        if (ld_hour2) c_ld[1] <= c_ld[1] + 1;
        if (ld_min1)  c_ld[2] <= c_ld[2] + 1;
        if (ld_min2)  c_ld[3] <= c_ld[3] + 1;
        if (ld_alarm) c_ld[4] <= c_ld[4] + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; go = 1'b0; alarm_edit = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        data_in = d; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base [5];
        int nt, last, i;
        logic [17:0] exp_v, act_v;
        fork
            forever begin
                @(negedge clk);
                if (cmp_en) begin
                    exp_v = {(m_pos == 5) ? 4'd10 : 4'(m_pos * 2 + int'(m_wait)), 4'(m_dig),
                             m_ld, m_tick, (m_pos == 5), m_err};
                    act_v = {state_dbg, digit_out, ld_alarm, ld_min2, ld_min1, ld_hour2,
                             ld_hour1, tick, running, entry_err};
                    check("cycle_model", int'(act_v), int'(exp_v));
                end
            end
        join_none

        #1 resetn = 1'b0;
        #1 cmp_en = 1;
        @(negedge clk);
        check("reset_state", int'(state_dbg), 0);
        check("reset_digit", int'(digit_out), 0);
        resetn = 1'b1;

        // Full entry 1,4,3,7 alarm 2
        base = c_ld;
        press(4'd1); press(4'd4); press(4'd3); press(4'd7); press(4'd2);
        for (int k = 0; k < 5; k++) check("ld_once", c_ld[k] - base[k], 1);
        check("run_state", int'(state_dbg), 10);
        check("run_flag", int'(running), 1);
        check("run_digit", int'(digit_out), 2);

        // H1 reject then accept
        do_reset();
        base = c_ld;
        @(negedge clk); data_in = 4'd3; go = 1'b1;
        repeat (3) @(negedge clk);
        check("h1_rej_err", int'(entry_err), 1);
        check("h1_rej_state", int'(state_dbg), 0);
        check("h1_rej_nold", c_ld[0] - base[0], 0);
        go = 1'b0;
        press(4'd2);
        check("h1_acc_ld", c_ld[0] - base[0], 1);
        check("h1_acc_err", int'(entry_err), 0);

        // H2 range depends on H1
        press(4'd4);
        check("h2_rej_state", int'(state_dbg), 2);
        check("h2_rej_err", int'(entry_err), 1);
        press(4'd3);
        check("h2_acc_state", int'(state_dbg), 4);
        check("h2_acc_digit", int'(digit_out), 3);
        do_reset();
        press(4'd1); press(4'd9);
        check("h2_9_state", int'(state_dbg), 4);
        check("h2_9_digit", int'(digit_out), 9);

        // Tick spacing in RUN
        do_reset();
        press(4'd1); press(4'd4); press(4'd3); press(4'd7); press(4'd2);
        nt = 0; last = 0;
        for (i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick) begin
                nt++;
                check("tick_pos", i, 5 * nt);
                last = i;
            end
        end
        check("tick_count", nt, 4);

        // Alarm edit with divider at 3, "no timer" code, resume without losing count
        repeat (3) @(negedge clk);
        alarm_edit = 1'b1;
        @(negedge clk);
        alarm_edit = 1'b0;
        check("ae_state", int'(state_dbg), 8);
        check("ae_running", int'(running), 0);
        base = c_ld;
        press(4'd9);
        check("ae_digit", int'(digit_out), 15);
        check("ae_ld", c_ld[4] - base[4], 1);
        check("ae_resume", int'(state_dbg), 10);
        @(negedge clk);
        check("ae_first_tick", int'(tick), 1);

        // Held go yields one strobe, then async reset mid-RUN
        do_reset();
        base = c_ld;
        @(negedge clk); data_in = 4'd1; go = 1'b1;
        repeat (10) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        check("hold_ld", c_ld[0] - base[0], 1);
        check("hold_state", int'(state_dbg), 2);
        press(4'd4); press(4'd3); press(4'd7); press(4'd2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_state", int'(state_dbg), 0);
        check("async_outs", int'({digit_out, ld_hour1, ld_hour2, ld_min1, ld_min2, ld_alarm,
                                  tick, running, entry_err}), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_set_sequencer.md
Name: clock_set_sequencer

Overview:
- Control FSM that sequences HH:MM entry and alarm-preset selection for the clock datapath.
- Digits are entered one per debounced "go" press/release; each digit is range-checked before the datapath sees it.
- In run mode it generates the 1 Hz tick that the datapath uses to advance time and decrement the timer.
- Sits between the top-level key/switch inputs and the datapath. It owns every load strobe and the tick.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick (>=2); tick fires when the divider reaches TICK_DIV-1.
- CNT_W, 26, divider counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- go  input  1  level "enter" key, active-high, already synchronised
- alarm_edit  input  1  active-high request to re-enter alarm selection
- data_in  input  4  BCD digit / alarm code from switches
- digit_out  output  4  registered copy of the last accepted value
- ld_hour1, ld_hour2, ld_min1, ld_min2, ld_alarm  output  1 each  one-cycle load strobes, at most one high per cycle
- tick  output  1  one-cycle 1 Hz pulse, only in RUN
- running  output  1  high while in RUN
- entry_err  output  1  sticky flag: last attempted entry was out of range
- state_dbg  output  4  current state encoding

Behaviour:
- States and encodings:
  - Entry states: H1=0, H1W=1, H2=2, H2W=3, M1=4, M1W=5, M2=6, M2W=7, AL=8, ALW=9.
  - RUN=10.
  - Encodings 11-15 are illegal and go to H1 on the next clk.
- Reset (resetn low, asynchronous):
  - state=H1; digit_out=0; all ld_* outputs 0; tick=0; running=0; entry_err=0; divider=0; internal h1_latched=0.
- Entry state X (H1, H2, M1, M2, AL), go high, data_in valid:
  - Next cycle: state goes to XW.
  - In that same cycle: the matching ld_* is high for exactly one cycle, digit_out=data_in, entry_err clears.
  - Strobe latency is 1 clk after go is sampled high.
- Entry state X, go high, data_in invalid:
  - State stays X; no strobe; entry_err=1.
  - The sequencer waits for go low before it evaluates again, so holding go cannot generate repeated errors. An internal armed bit is cleared on reject and set when go is low.
- Wait state XW: remain while go=1; go=0 moves to the next entry state (ALW goes to RUN).
- Validity rules:
  - H1: data_in <= 2. On accept, h1_latched is captured.
  - H2: if h1_latched=2, data_in <= 3; otherwise data_in <= 9.
  - M1: data_in <= 5.
  - M2: data_in <= 9.
  - AL: data_in <= 3 (codes 0-3 map to 15/30/45/60 s). data_in 4-15 is accepted as code 0xF, meaning "no timer"; digit_out=0xF and AL is never rejected.
- RUN:
  - running=1.
  - Divider increments every clk. At TICK_DIV-1 it wraps to 0 and tick=1 for that single cycle.
  - go is ignored in RUN.
- alarm_edit:
  - Sampled in RUN only. RUN goes to AL; running drops next cycle; the divider holds its value and does not reset.
  - Re-entering RUN resumes the count without losing a partial second.
  - alarm_edit in any entry state is ignored.
- Simultaneous alarm_edit and divider wrap in RUN: the tick is still emitted that cycle, then the state goes to AL.
- Reset mid-entry or mid-RUN: immediate return to the reset values above; the HH:MM sequence restarts at H1.
- Strobes are combinational-free: every output comes directly from a flop.

Test Plan:
- Reset, then enter 1,4,3,7,alarm 2 with press/release → ld_hour1..ld_alarm each pulse once in order; digit_out 1,4,3,7,2; state ends at 10; running=1.
- In H1 present data_in=3 with go → entry_err=1, state stays 0, no strobe. Release, then press with 2 → ld_hour1 pulse, entry_err=0.
- H1=2 accepted; H2 with 4 → rejected. H2 with 3 → accepted. Repeat with H1=1 and H2=9 → accepted.
- TICK_DIV=5 in RUN for 20 cycles → tick pulses exactly 4 times, spaced 5 clk apart, each 1 cycle wide.
- In RUN, assert alarm_edit with the divider at 3 (TICK_DIV=5), enter alarm 9 → digit_out=0xF and ld_alarm pulse. Back in RUN, the first tick arrives 1 clk after the divider resumes (divider retained).
- Hold go high across H1 for 10 cycles with a valid digit → exactly one ld_hour1 pulse. Drop resetn asynchronously mid-RUN → state 0 and all outputs 0 before the next clk edge.
